// File: rtl/pipeline_hazard_unit_pkg.sv
// hazard_pkg: shared constants and types for the pipeline hazard unit.
// Holds the operand-forward select encodings, the long-latency unit FSM
// state type and the default post-redirect flush length.
package hazard_pkg;

    // Operand source selects driven to the ID-stage operand muxes
    localparam logic [1:0] FWD_RF    = 2'd0;
    localparam logic [1:0] FWD_EXE   = 2'd1;
    localparam logic [1:0] FWD_MEM   = 2'd2;
    localparam logic [1:0] FWD_MEMLD = 2'd3;

    // Number of NOP cycles injected after a control-flow redirect
    localparam int DEFAULT_FLUSH_CYCLES = 2;

    // Occupancy of the single long-latency (mul/div) unit
    typedef enum logic {
        L_IDLE = 1'b0,
        L_BUSY = 1'b1
    } longState_e;

endpackage

// File: rtl/pipeline_hazard_unit_if.sv
// pipeline_hazard_unit_if: bundle between the pipeline control path and the
// hazard unit. The master side (pipeline) drives the ID/EXE/MEM register
// information and the long-op / redirect events; the slave side (hazard
// unit) returns forward selects, stall controls and status.
interface pipeline_hazard_unit_if #(
    parameter int RA_W = 5
);

    // ID-stage instruction fields
    logic            idValid;
    logic [RA_W-1:0] idRs1;
    logic [RA_W-1:0] idRs2;
    logic            idUsesRs1;
    logic            idUsesRs2;
    logic [RA_W-1:0] idRd;
    logic            idWreg;
    logic            idLong;

    // EXE / MEM stage destination information
    logic [RA_W-1:0] erd;
    logic [RA_W-1:0] mrd;
    logic            ewreg;
    logic            mwreg;
    logic            em2reg;
    logic            mm2reg;

    // Events
    logic            longDone;
    logic            redirect;

    // Hazard unit results
    logic [1:0]      qaSel;
    logic [1:0]      qbSel;
    logic            pcStall;
    logic            ifidStall;
    logic            instNop;
    logic            longBusy;
    logic            flushActive;

    modport master (
        output idValid, idRs1, idRs2, idUsesRs1, idUsesRs2, idRd, idWreg, idLong,
        output erd, mrd, ewreg, mwreg, em2reg, mm2reg,
        output longDone, redirect,
        input  qaSel, qbSel, pcStall, ifidStall, instNop, longBusy, flushActive
    );

    modport slave (
        input  idValid, idRs1, idRs2, idUsesRs1, idUsesRs2, idRd, idWreg, idLong,
        input  erd, mrd, ewreg, mwreg, em2reg, mm2reg,
        input  longDone, redirect,
        output qaSel, qbSel, pcStall, ifidStall, instNop, longBusy, flushActive
    );

endinterface

// File: rtl/pipeline_hazard_unit_fwd_select.sv
// fwd_select: per-operand forwarding select and load-use detection.
// A result still sitting in EXE beats an older one in MEM; an EXE load
// cannot be forwarded yet, so it raises loadUse_o instead. Register x0 and
// unused operands never match.
module fwd_select
    import hazard_pkg::*;
#(
    parameter int RA_W = 5
) (
    input  logic [RA_W-1:0] rs_i,
    input  logic            uses_i,
    input  logic [RA_W-1:0] erd_i,
    input  logic            ewreg_i,
    input  logic            em2reg_i,
    input  logic [RA_W-1:0] mrd_i,
    input  logic            mwreg_i,
    input  logic            mm2reg_i,
    output logic [1:0]      sel_o,
    output logic            loadUse_o
);

    logic srcLive;
    logic exeHit;
    logic memHit;

    assign srcLive = uses_i && (rs_i != '0);
    assign exeHit  = srcLive && ewreg_i && (erd_i == rs_i);
    assign memHit  = srcLive && mwreg_i && (mrd_i == rs_i);

    // Pick the youngest forwardable producer and flag an unforwardable EXE load
    always_comb begin
        sel_o     = FWD_RF;
        loadUse_o = exeHit && em2reg_i;
        if (exeHit && !em2reg_i) begin
            sel_o = FWD_EXE;
        end else if (memHit) begin
            sel_o = mm2reg_i ? FWD_MEMLD : FWD_MEM;
        end
    end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// pipeline_hazard_unit: ID-stage hazard control.
// Produces operand forward selects, PC/IFID stall and NOP injection. Adds a
// load-use interlock, a scoreboard plus FSM tracking one outstanding
// long-latency op, and a post-redirect flush counter.
// Optional build macro: HAZARD_PERF_EN adds saturating stallCount and
// flushCount performance counter ports.
module pipeline_hazard_unit
    import hazard_pkg::*;
#(
    parameter int RA_W         = 5,
    parameter int NUM_REGS     = 32,
    parameter int FLUSH_CYCLES = DEFAULT_FLUSH_CYCLES,
    parameter int CNT_W        = 32
) (
    input logic                   clk,
    input logic                   resetN,
    pipeline_hazard_unit_if.slave hz
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0]      stallCount,
    output logic [CNT_W-1:0]      flushCount
`endif
);

    // Reject configurations the scoreboard and flush counter cannot represent
    if (NUM_REGS != (1 << RA_W)) begin : gBadNumRegs
        $error("pipeline_hazard_unit: NUM_REGS must equal 2**RA_W");
    end
    if ((FLUSH_CYCLES < 1) || (FLUSH_CYCLES > 7)) begin : gBadFlush
        $error("pipeline_hazard_unit: FLUSH_CYCLES must be in 1..7");
    end
    if (CNT_W < 1) begin : gBadCntW
        $error("pipeline_hazard_unit: CNT_W must be positive");
    end

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    // State
    longState_e          state_q, state_d;
    logic [RA_W-1:0]     longRd_q, longRd_d;
    logic [NUM_REGS-1:0] sb_q, sb_d;
    logic [2:0]          flushCnt_q, flushCnt_d;

    // Combinational hazard terms
    logic [1:0]          selA, selB;
    logic                loadUseA, loadUseB;
    logic                doneSeen;
    logic [NUM_REGS-1:0] sbLive;
    logic                rawHit, wawHit, structHit;
    logic                stall;
    logic                flushNow;
    logic                accept;

    fwd_select #(.RA_W(RA_W)) uFwdA (
        .rs_i      (hz.idRs1),
        .uses_i    (hz.idUsesRs1),
        .erd_i     (hz.erd),
        .ewreg_i   (hz.ewreg),
        .em2reg_i  (hz.em2reg),
        .mrd_i     (hz.mrd),
        .mwreg_i   (hz.mwreg),
        .mm2reg_i  (hz.mm2reg),
        .sel_o     (selA),
        .loadUse_o (loadUseA)
    );

    fwd_select #(.RA_W(RA_W)) uFwdB (
        .rs_i      (hz.idRs2),
        .uses_i    (hz.idUsesRs2),
        .erd_i     (hz.erd),
        .ewreg_i   (hz.ewreg),
        .em2reg_i  (hz.em2reg),
        .mrd_i     (hz.mrd),
        .mwreg_i   (hz.mwreg),
        .mm2reg_i  (hz.mm2reg),
        .sel_o     (selB),
        .loadUse_o (loadUseB)
    );

    // longDone only counts while an op is really in flight; after a reset
    // abandoned the op, a late completion is ignored
    assign doneSeen = hz.longDone && (state_q == L_BUSY);

    // The register file writes through, so the completing op's bit is
    // already treated as clear in its write-back cycle
    always_comb begin
        sbLive = sb_q;
        if (doneSeen) begin
            sbLive[longRd_q] = 1'b0;
        end
    end

    // Long-op RAW / WAW / structural hazards against the live scoreboard
    always_comb begin
        rawHit    = (hz.idUsesRs1 && (hz.idRs1 != '0) && sbLive[hz.idRs1]) ||
                    (hz.idUsesRs2 && (hz.idRs2 != '0) && sbLive[hz.idRs2]);
        wawHit    = hz.idWreg && (hz.idRd != '0) && sbLive[hz.idRd];
        structHit = hz.idLong && (state_q != L_IDLE);
    end

    assign stall    = hz.idValid && (loadUseA || loadUseB || rawHit || wawHit || structHit);
    assign flushNow = (flushCnt_q != 3'd0) || hz.redirect;
    assign accept   = hz.idValid && hz.idLong && !stall && !flushNow;

    // Long-unit FSM and destination register of the in-flight op
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q  <= L_IDLE;
            longRd_q <= '0;
        end else begin
            state_q  <= state_d;
            longRd_q <= longRd_d;
        end
    end

    // Accept moves the unit to busy, completion returns it to idle
    always_comb begin
        state_d  = state_q;
        longRd_d = longRd_q;
        case (state_q)
            L_IDLE: begin
                if (accept) begin
                    state_d  = L_BUSY;
                    longRd_d = hz.idRd;
                end
            end
            L_BUSY: begin
                if (hz.longDone) begin
                    state_d = L_IDLE;
                end
            end
            default: begin
                state_d = L_IDLE;
            end
        endcase
    end

    // Scoreboard next state: retire on completion, mark on accept (never x0)
    always_comb begin
        sb_d = sbLive;
        if (accept && (hz.idRd != '0)) begin
            sb_d[hz.idRd] = 1'b1;
        end
    end

    // Scoreboard register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    // Redirect reloads the flush length, otherwise count down to zero
    always_comb begin
        flushCnt_d = flushCnt_q;
        if (hz.redirect) begin
            flushCnt_d = FLUSH_LOAD;
        end else if (flushCnt_q != 3'd0) begin
            flushCnt_d = flushCnt_q - 3'd1;
        end
    end

    // Flush counter register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            flushCnt_q <= 3'd0;
        end else begin
            flushCnt_q <= flushCnt_d;
        end
    end

    // Output controls; flush wins over stall and reset forces a quiet bubble
    always_comb begin
        hz.qaSel       = FWD_RF;
        hz.qbSel       = FWD_RF;
        hz.pcStall     = 1'b0;
        hz.ifidStall   = 1'b0;
        hz.instNop     = 1'b1;
        hz.longBusy    = 1'b0;
        hz.flushActive = 1'b0;
        if (resetN) begin
            hz.qaSel       = selA;
            hz.qbSel       = selB;
            hz.pcStall     = stall && !flushNow;
            hz.ifidStall   = stall && !flushNow;
            hz.instNop     = stall || flushNow;
            hz.longBusy    = (state_q == L_BUSY);
            hz.flushActive = flushNow;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stallCount_q;
    logic [CNT_W-1:0] flushCount_q;

    // Saturating counts of stall cycles outside flush and of flush cycles
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            stallCount_q <= '0;
            flushCount_q <= '0;
        end else begin
            if (stall && !flushNow && (stallCount_q != '1)) begin
                stallCount_q <= stallCount_q + CNT_W'(1);
            end
            if (flushNow && (flushCount_q != '1)) begin
                flushCount_q <= flushCount_q + CNT_W'(1);
            end
        end
    end

    assign stallCount = stallCount_q;
    assign flushCount = flushCount_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// tb_pipeline_hazard_unit: directed plus randomized stimulus for
// pipeline_hazard_unit, compared against an abstract model that tracks the
// outstanding long op, the remaining flush cycles and the perf counts.
// With HAZARD_PERF_EN defined the counter ports are connected and checked.
module tb_pipeline_hazard_unit;
    import hazard_pkg::*;

    localparam int RA_W = 5;
    localparam int FC   = 2;

    logic clk;
    logic resetN;

    pipeline_hazard_unit_if #(.RA_W(RA_W)) hz ();

`ifdef HAZARD_PERF_EN
    logic [31:0] stallCount;
    logic [31:0] flushCount;
`endif

    pipeline_hazard_unit #(
        .RA_W         (RA_W),
        .NUM_REGS     (32),
        .FLUSH_CYCLES (FC),
        .CNT_W        (32)
    ) dut (
        .clk        (clk),
        .resetN     (resetN),
        .hz         (hz)
`ifdef HAZARD_PERF_EN
        ,
        .stallCount (stallCount),
        .flushCount (flushCount)
`endif
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit idValid;
        int rs1;
        int rs2;
        bit uses1;
        bit uses2;
        int rd;
        bit wreg;
        bit isLong;
        int erd;
        int mrd;
        bit ewreg;
        bit mwreg;
        bit em2reg;
        bit mm2reg;
        bit longDone;
        bit redirect;
    } stim_t;

    stim_t s;

    // Reference model state
    bit mBusy;
    int mBusyRd;
    int mFlushLeft;
    int mStalls;
    int mFlushes;

    // Predicted values for the current cycle
    int eQa, eQb;
    bit eStall, eFlush, eAccept;

    int passCount  = 0;
    int checkCount = 0;
    int failCount  = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            $error("[TB] check %s did not hold", tag);
        end
    endtask

    function automatic int fwdRef(input int rs, input bit uses);
        if (!uses || rs == 0) return 0;
        if (s.ewreg && s.erd == rs && !s.em2reg) return 1;
        if (s.mwreg && s.mrd == rs) return s.mm2reg ? 3 : 2;
        return 0;
    endfunction

    function automatic bit loadUseRef(input int rs, input bit uses);
        return uses && rs != 0 && s.ewreg && s.em2reg && s.erd == rs;
    endfunction

    task automatic predict();
        int pending;
        bit raw, waw, structural, lu;
        pending    = (mBusy && !s.longDone) ? mBusyRd : 0;
        raw        = pending != 0 && ((s.uses1 && s.rs1 == pending) || (s.uses2 && s.rs2 == pending));
        waw        = pending != 0 && s.wreg && s.rd == pending;
        structural = s.isLong && mBusy;
        lu         = loadUseRef(s.rs1, s.uses1) || loadUseRef(s.rs2, s.uses2);
        eQa        = fwdRef(s.rs1, s.uses1);
        eQb        = fwdRef(s.rs2, s.uses2);
        eStall     = s.idValid && (lu || raw || waw || structural);
        eFlush     = (mFlushLeft > 0) || s.redirect;
        eAccept    = s.idValid && s.isLong && !eStall && !eFlush;
    endtask

    task automatic applyStimulus(input stim_t st);
        s            = st;
        hz.idValid   = st.idValid;
        hz.idRs1     = st.rs1[RA_W-1:0];
        hz.idRs2     = st.rs2[RA_W-1:0];
        hz.idUsesRs1 = st.uses1;
        hz.idUsesRs2 = st.uses2;
        hz.idRd      = st.rd[RA_W-1:0];
        hz.idWreg    = st.wreg;
        hz.idLong    = st.isLong;
        hz.erd       = st.erd[RA_W-1:0];
        hz.mrd       = st.mrd[RA_W-1:0];
        hz.ewreg     = st.ewreg;
        hz.mwreg     = st.mwreg;
        hz.em2reg    = st.em2reg;
        hz.mm2reg    = st.mm2reg;
        hz.longDone  = st.longDone;
        hz.redirect  = st.redirect;
    endtask

    task automatic clearStim();
        s = '{default: 0};
    endtask

    task automatic checkAll(input string tag);
        predict();
        checkOutput({tag, ".qaSel"},       32'(hz.qaSel),       32'(eQa));
        checkOutput({tag, ".qbSel"},       32'(hz.qbSel),       32'(eQb));
        checkOutput({tag, ".pcStall"},     32'(hz.pcStall),     32'(eStall && !eFlush));
        checkOutput({tag, ".ifidStall"},   32'(hz.ifidStall),   32'(eStall && !eFlush));
        checkOutput({tag, ".instNop"},     32'(hz.instNop),     32'(eStall || eFlush));
        checkOutput({tag, ".longBusy"},    32'(hz.longBusy),    32'(mBusy));
        checkOutput({tag, ".flushActive"}, 32'(hz.flushActive), 32'(eFlush));
`ifdef HAZARD_PERF_EN
        checkOutput({tag, ".stallCount"},  stallCount,          32'(mStalls));
        checkOutput({tag, ".flushCount"},  flushCount,          32'(mFlushes));
`endif
    endtask

    // Drive the current stimulus, let it settle, compare against the model
    task automatic cycle(input string tag);
        applyStimulus(s);
        #3;
        checkAll(tag);
    endtask

    // Advance one clock and move the model forward with the same inputs
    task automatic tick();
        @(posedge clk);
        if (mBusy && s.longDone) mBusy = 1'b0;
        if (eAccept) begin
            mBusy   = 1'b1;
            mBusyRd = s.rd;
        end
        mFlushLeft = s.redirect ? FC : ((mFlushLeft > 0) ? mFlushLeft - 1 : 0);
        if (eStall && !eFlush) mStalls++;
        if (eFlush) mFlushes++;
        #1;
    endtask

    // Assert reset with hazard-provoking inputs, check forced outputs, release
    task automatic resetCheck(input string tag);
        resetN = 1'b0;
        #2;
        checkOutput({tag, ".qaSel"},       32'(hz.qaSel),       32'd0);
        checkOutput({tag, ".qbSel"},       32'(hz.qbSel),       32'd0);
        checkOutput({tag, ".pcStall"},     32'(hz.pcStall),     32'd0);
        checkOutput({tag, ".ifidStall"},   32'(hz.ifidStall),   32'd0);
        checkOutput({tag, ".instNop"},     32'(hz.instNop),     32'd1);
        checkOutput({tag, ".longBusy"},    32'(hz.longBusy),    32'd0);
        checkOutput({tag, ".flushActive"}, 32'(hz.flushActive), 32'd0);
`ifdef HAZARD_PERF_EN
        checkOutput({tag, ".stallCount"},  stallCount,          32'd0);
        checkOutput({tag, ".flushCount"},  flushCount,          32'd0);
`endif
        mBusy      = 1'b0;
        mBusyRd    = 0;
        mFlushLeft = 0;
        mStalls    = 0;
        mFlushes   = 0;
        @(posedge clk);
        #1;
        resetN = 1'b1;
    endtask

    initial begin
        // Reset with matches, a redirect and a long op all presented
        clearStim();
        s.idValid = 1; s.rs1 = 5; s.uses1 = 1; s.erd = 5; s.ewreg = 1;
        s.redirect = 1; s.isLong = 1; s.rd = 4; s.wreg = 1;
        applyStimulus(s);
        #1;
        resetCheck("reset");

        // Forwarding: EXE ALU beats MEM load, then MEM load, then x0
        clearStim();
        s.idValid = 1; s.rs1 = 5; s.uses1 = 1;
        s.erd = 5; s.ewreg = 1; s.mrd = 5; s.mwreg = 1; s.mm2reg = 1;
        cycle("fwdExe");
        checkOutput("fwdExePrio", 32'(hz.qaSel), 32'd1);
        tick();
        s.ewreg = 0;
        cycle("fwdMemLd");
        checkOutput("fwdMemLoad", 32'(hz.qaSel), 32'd3);
        tick();
        s.rs1 = 0; s.erd = 0; s.ewreg = 1; s.mrd = 0;
        s.rs2 = 6; s.uses2 = 1;
        cycle("fwdX0");
        checkOutput("fwdX0Sel", 32'(hz.qaSel), 32'd0);
        tick();
        s.mrd = 6; s.mm2reg = 0;
        cycle("fwdMemAlu");
        checkOutput("fwdMemAluSel", 32'(hz.qbSel), 32'd2);
        tick();

        // Load-use: one stall cycle, then the load forwards from MEM
        clearStim();
        s.idValid = 1; s.rs1 = 7; s.uses1 = 1;
        s.erd = 7; s.ewreg = 1; s.em2reg = 1;
        cycle("luStall");
        checkOutput("luPcStall", 32'(hz.pcStall), 32'd1);
        checkOutput("luNop", 32'(hz.instNop), 32'd1);
        tick();
        s.ewreg = 0; s.em2reg = 0; s.mrd = 7; s.mwreg = 1; s.mm2reg = 1;
        cycle("luFwd");
        checkOutput("luFwdSel", 32'(hz.qaSel), 32'd3);
        checkOutput("luClear", 32'(hz.pcStall), 32'd0);
        tick();

        // Long op to x9: RAW, WAW and structural stalls until longDone
        clearStim();
        s.idValid = 1; s.isLong = 1; s.rd = 9; s.wreg = 1;
        cycle("longAccept");
        checkOutput("longAcceptNoStall", 32'(hz.pcStall), 32'd0);
        tick();
        clearStim();
        s.idValid = 1; s.rs1 = 9; s.uses1 = 1;
        for (int i = 0; i < 2; i++) begin
            cycle("longRaw");
            checkOutput("longRawStall", 32'(hz.pcStall), 32'd1);
            checkOutput("longBusyHigh", 32'(hz.longBusy), 32'd1);
            tick();
        end
        clearStim();
        s.idValid = 1; s.rd = 9; s.wreg = 1;
        cycle("longWaw");
        checkOutput("longWawStall", 32'(hz.pcStall), 32'd1);
        tick();
        s.rd = 12; s.isLong = 1;
        cycle("longStruct");
        checkOutput("longStructStall", 32'(hz.pcStall), 32'd1);
        tick();
        clearStim();
        s.idValid = 1; s.rs1 = 9; s.uses1 = 1; s.longDone = 1;
        cycle("longDone");
        checkOutput("longDoneNoStall", 32'(hz.pcStall), 32'd0);
        checkOutput("longDoneSel", 32'(hz.qaSel), 32'd0);
        tick();
        s.longDone = 0;
        cycle("longIdle");
        checkOutput("longIdleBusy", 32'(hz.longBusy), 32'd0);
        tick();

        // Flush overrides a load-use stall, lasts pulse + FC cycles
        clearStim();
        s.idValid = 1; s.rs1 = 7; s.uses1 = 1;
        s.erd = 7; s.ewreg = 1; s.em2reg = 1; s.redirect = 1;
        cycle("flushPulse");
        checkOutput("flushPulseNop", 32'(hz.instNop), 32'd1);
        checkOutput("flushPulseNoStall", 32'(hz.pcStall), 32'd0);
        tick();
        s.redirect = 0;
        for (int i = 0; i < FC; i++) begin
            cycle("flushHold");
            checkOutput("flushHoldActive", 32'(hz.flushActive), 32'd1);
            checkOutput("flushHoldNoStall", 32'(hz.pcStall), 32'd0);
            tick();
        end
        cycle("flushEnd");
        checkOutput("flushEndActive", 32'(hz.flushActive), 32'd0);
        checkOutput("flushEndStall", 32'(hz.pcStall), 32'd1);
        tick();

        // Second redirect on cycle 2 reloads the counter
        clearStim();
        s.idValid = 1; s.redirect = 1;
        cycle("reflush0");
        tick();
        s.redirect = 0;
        cycle("reflush1");
        tick();
        s.redirect = 1;
        cycle("reflush2");
        tick();
        s.redirect = 0;
        for (int i = 0; i < FC; i++) begin
            cycle("reflushHold");
            checkOutput("reflushHoldActive", 32'(hz.flushActive), 32'd1);
            tick();
        end
        cycle("reflushEnd");
        checkOutput("reflushEndNop", 32'(hz.instNop), 32'd0);
        tick();

        // A long op during flush is not accepted
        clearStim();
        s.idValid = 1; s.isLong = 1; s.rd = 10; s.wreg = 1; s.redirect = 1;
        cycle("flushLong");
        tick();
        clearStim();
        for (int i = 0; i < FC; i++) begin
            cycle("flushLongDrain");
            checkOutput("flushLongNotBusy", 32'(hz.longBusy), 32'd0);
            tick();
        end

        // Reset while busy abandons the op; a late longDone is ignored
        clearStim();
        s.idValid = 1; s.isLong = 1; s.rd = 9; s.wreg = 1;
        cycle("rstAccept");
        tick();
        clearStim();
        s.idValid = 1; s.rs1 = 9; s.uses1 = 1; s.erd = 9; s.ewreg = 1; s.redirect = 1;
        cycle("rstBusy");
        checkOutput("rstBusyHigh", 32'(hz.longBusy), 32'd1);
        resetCheck("rstMid");
        clearStim();
        s.idValid = 1; s.rs1 = 9; s.uses1 = 1; s.longDone = 1;
        cycle("rstLateDone");
        checkOutput("rstLateNoStall", 32'(hz.pcStall), 32'd0);
        tick();
        clearStim();
        s.idValid = 1; s.isLong = 1; s.rd = 3; s.wreg = 1;
        cycle("rstNewLong");
        checkOutput("rstNewAccept", 32'(hz.pcStall), 32'd0);
        tick();
        clearStim();
        s.longDone = 1;
        cycle("rstNewDone");
        checkOutput("rstNewBusy", 32'(hz.longBusy), 32'd1);
        tick();

        // Perf scenario: 3 load-use stalls then one redirect
        clearStim();
        applyStimulus(s);
        resetCheck("perfReset");
        s.idValid = 1; s.rs2 = 11; s.uses2 = 1;
        s.erd = 11; s.ewreg = 1; s.em2reg = 1;
        for (int i = 0; i < 3; i++) begin
            cycle("perfStall");
            tick();
        end
        clearStim();
        s.redirect = 1;
        cycle("perfRedirect");
        tick();
        s.redirect = 0;
        for (int i = 0; i < FC + 1; i++) begin
            cycle("perfDrain");
            tick();
        end
`ifdef HAZARD_PERF_EN
        checkOutput("perfStallCount", stallCount, 32'd3);
        checkOutput("perfFlushCount", flushCount, 32'd3);
`endif

        // Randomized traffic over a small register window to force matches
        for (int n = 0; n < 400; n++) begin
            s.idValid  = ($urandom_range(3) != 0);
            s.rs1      = $urandom_range(7);
            s.rs2      = $urandom_range(7);
            s.uses1    = $urandom_range(1);
            s.uses2    = $urandom_range(1);
            s.rd       = $urandom_range(7);
            s.wreg     = $urandom_range(1);
            s.isLong   = ($urandom_range(5) == 0);
            s.erd      = $urandom_range(7);
            s.mrd      = $urandom_range(7);
            s.ewreg    = $urandom_range(1);
            s.mwreg    = $urandom_range(1);
            s.em2reg   = $urandom_range(1);
            s.mm2reg   = $urandom_range(1);
            s.longDone = ($urandom_range(3) == 0);
            s.redirect = ($urandom_range(15) == 0);
            cycle("rnd");
            tick();
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
